switch_round_ctrl: RTL and testbench



---
 rtl/switch_game_pkg.sv | 19 +
 rtl/prompt_lfsr.sv | 39 +++
 rtl/switch_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_switch_round_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/switch_game_pkg.sv
// Shared types and constants for the switch game round sequencer.
package switch_game_pkg;
  localparam int STATE_W   = 3;
  localparam int SCORE_MAX = 99;
  localparam int SCORE_W   = 7;
  localparam int TIME_W    = 6;
  localparam int LFSR_W    = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, bits numbered from 1 at the LSB
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE, ST_PROMPT, ST_WAIT, ST_SETTLE, ST_JUDGE, ST_MISS, ST_OVER
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/prompt_lfsr.sv
// Prompt generator: LFSR reduced mod NSW, never repeating the previous index.
module prompt_lfsr import switch_game_pkg::*; #(
  parameter int                NSW       = 10,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_i,
  output logic [$clog2(NSW)-1:0]   idx_o,
  output logic [NSW-1:0]           onehot_o
);
  localparam int IDX_W = $clog2(NSW);

  logic [LFSR_W-1:0] lfsr_q, raw_w;
  logic [IDX_W-1:0]  raw_idx, prev_q;
  logic              prev_vld_q;

  always_comb begin
    raw_w   = lfsr_q % LFSR_W'(NSW);
    raw_idx = raw_w[IDX_W-1:0];
    idx_o   = raw_idx;
    // prev_vld_q keeps the very first prompt after reset unconstrained
    if (prev_vld_q && raw_idx == prev_q)
      idx_o = (raw_idx == IDX_W'(NSW-1)) ? '0 : raw_idx + IDX_W'(1);
    onehot_o = NSW'(1) << idx_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q     <= LFSR_SEED;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (step_i) begin
      lfsr_q     <= lfsr_next(lfsr_q);
      prev_q     <= idx_o;
      prev_vld_q <= 1'b1;
    end
  end
endmodule

// File: rtl/switch_round_ctrl.sv
// Switch game round sequencer: prompt, debounce, judge, timer, score and lives.
// Optional HISCORE_EN adds hiscore_o, the best score since reset.
module switch_round_ctrl import switch_game_pkg::*; #(
  parameter int                NSW          = 10,
  parameter int                DEBOUNCE_CYC = 2500000,
  parameter int                ROUND_TIME   = 5,
  parameter int                MAX_LIVES    = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               tick_i,
  input  logic [NSW-1:0]     sw_i,
  output logic [NSW-1:0]     led_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         lives_o,
  output logic [TIME_W-1:0]  time_left_o,
  output logic               busy_o,
  output logic               game_over_o
`ifdef HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore_o
`endif
);
  localparam int IDX_W = $clog2(NSW);
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  state_t             state_q, state_d;
  logic [NSW-1:0]     ref_q, ref_d, target_q, target_d, snap_q, snap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NSW-1:0]     led_d, onehot;
  logic [IDX_W-1:0]   idx;
  logic [SCORE_W-1:0] score_d;
  logic [1:0]         lives_d;
  logic [TIME_W-1:0]  time_d;
  logic               busy_d, over_d, expire, settled;

  prompt_lfsr #(.NSW(NSW), .LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .step_i   (state_q == ST_PROMPT),
    .idx_o    (idx),
    .onehot_o (onehot)
  );

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    target_d = target_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    score_d  = score_o;
    lives_d  = lives_o;
    time_d   = time_left_o;
    expire   = tick_i && time_left_o == TIME_W'(1);
    settled  = sw_i == snap_q && sw_i != ref_q && cnt_q == CNT_LAST;

    case (state_q)
      ST_IDLE, ST_OVER: if (start_i) begin
        score_d = '0;
        lives_d = 2'(MAX_LIVES);
        state_d = ST_PROMPT;
      end
      ST_PROMPT: begin
        ref_d    = sw_i;
        target_d = sw_i ^ (NSW'(1) << idx);
        time_d   = TIME_W'(ROUND_TIME);
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tick_i && time_left_o != '0) time_d = time_left_o - TIME_W'(1);
        if (expire) state_d = ST_MISS;
        else if (sw_i != ref_q) begin
          snap_d  = sw_i;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tick_i && time_left_o != '0) time_d = time_left_o - TIME_W'(1);
        if (sw_i != snap_q) begin
          snap_d = sw_i;
          cnt_d  = '0;
        end else if (sw_i == ref_q) state_d = ST_WAIT;
        else cnt_d = cnt_q + CNT_W'(1);
        // a completed debounce beats a timeout landing on the same cycle
        if (settled) state_d = ST_JUDGE;
        else if (expire) state_d = ST_MISS;
      end
      ST_JUDGE: begin
        if (snap_q == target_q) begin
          score_d = (score_o >= SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_o + SCORE_W'(1);
          state_d = ST_PROMPT;
        end else state_d = ST_MISS;
      end
      ST_MISS: begin
        lives_d = lives_o - 2'd1;
        state_d = (lives_o == 2'd1) ? ST_OVER : ST_PROMPT;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = state_d inside {ST_PROMPT, ST_WAIT, ST_SETTLE, ST_JUDGE, ST_MISS};
    over_d = state_d == ST_OVER;
    if (state_d == ST_OVER)       led_d = '1;
    else if (state_d == ST_IDLE)  led_d = '0;
    else if (state_q == ST_PROMPT) led_d = onehot;
    else                          led_d = led_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      led_o       <= '0;
      score_o     <= '0;
      lives_o     <= 2'(MAX_LIVES);
      time_left_o <= TIME_W'(ROUND_TIME);
      busy_o      <= 1'b0;
      game_over_o <= 1'b0;
      ref_q       <= '0;
      target_q    <= '0;
      snap_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      led_o       <= led_d;
      score_o     <= score_d;
      lives_o     <= lives_d;
      time_left_o <= time_d;
      busy_o      <= busy_d;
      game_over_o <= over_d;
      ref_q       <= ref_d;
      target_q    <= target_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef HISCORE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hiscore_o <= '0;
    else if (state_d == ST_OVER && state_q != ST_OVER && score_o > hiscore_o)
      hiscore_o <= score_o;
  end
`endif
endmodule

// File: tb/tb_switch_round_ctrl.sv
// Scoreboard bench: stimulus queues expected status snapshots, monitor checks each change.
module tb_switch_round_ctrl;
  localparam int NSW = 10;

  logic           clk = 1'b0, reset = 1'b1, start_i = 1'b0, tick_i = 1'b0;
  logic [NSW-1:0] sw_i = '0, led_o;
  logic [6:0]     score_o;
  logic [1:0]     lives_o;
  logic [5:0]     time_left_o;
  logic           busy_o, game_over_o;
`ifdef HISCORE_EN
  logic [6:0]     hiscore_o;
`endif

  switch_round_ctrl #(.NSW(NSW), .DEBOUNCE_CYC(4), .ROUND_TIME(5), .MAX_LIVES(3),
                      .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .tick_i(tick_i), .sw_i(sw_i),
    .led_o(led_o), .score_o(score_o), .lives_o(lives_o), .time_left_o(time_left_o),
    .busy_o(busy_o), .game_over_o(game_over_o)
`ifdef HISCORE_EN
    , .hiscore_o(hiscore_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] score; logic [1:0] lives; logic [5:0] tl; logic busy; logic over; logic [6:0] hi;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0, n_fail = 0;
  int  es = 0, el = 3, ehi = 0;

  function automatic string ev_str(ev_t e);
    return $sformatf("score=%0d lives=%0d time=%0d busy=%0b over=%0b hi=%0d",
                     e.score, e.lives, e.tl, e.busy, e.over, e.hi);
  endfunction

  task automatic push(int s, int l, int t, bit b, bit o);
    ev_t e;
    e.score = 7'(s); e.lives = 2'(l); e.tl = 6'(t); e.busy = b; e.over = o; e.hi = 7'(ehi);
    exp_q.push_back(e);
  endtask

  function automatic int hot_idx(logic [NSW-1:0] l);
    for (int i = 0; i < NSW; i++) if (l[i]) return i;
    return 0;
  endfunction

  // Monitor: every change of the status tuple must match the next queued expectation
  ev_t            cur, last, want;
  bit             first = 1'b1, ok;
  logic [NSW-1:0] led_last, prev_hot = '0;

  always @(posedge clk) begin
    #1;
    cur.score = score_o; cur.lives = lives_o; cur.tl = time_left_o;
    cur.busy = busy_o; cur.over = game_over_o;
`ifdef HISCORE_EN
    cur.hi = hiscore_o;
`else
    cur.hi = '0;
`endif
    if (first || cur !== last) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL status_event: got %s, required no change", ev_str(cur));
      end else begin
        want = exp_q.pop_front();
        if (cur !== want) begin
          n_fail++;
          $display("FAIL status_event: got %s, required %s", ev_str(cur), ev_str(want));
        end
      end
    end
    if (first || led_o !== led_last) begin
      n_tests++;
      if (game_over_o) ok = (led_o === '1);
      else if (!busy_o) ok = (led_o === '0);
      else begin
        ok = $onehot(led_o) && led_o !== prev_hot;
        prev_hot = led_o;
      end
      if (!ok) begin
        n_fail++;
        $display("FAIL led_pattern: got %h, required per busy=%0b over=%0b (prev prompt %h)",
                 led_o, busy_o, game_over_o, prev_hot);
      end
    end
    last = cur; led_last = led_o; first = 1'b0;
  end

  // Stimulus tasks start and end just after a falling edge with the DUT in WAIT
  task automatic start_game();
    es = 0; el = 3;
    push(0, 3, 5, 1, 0);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0; @(negedge clk);
  endtask

  task automatic correct();
    int i;
    i = hot_idx(led_o);
    sw_i[i] = ~sw_i[i];
    if (es < 99) begin es++; push(es, el, 5, 1, 0); end
    repeat (7) @(negedge clk);
  endtask

  task automatic wrong();
    int i;
    i = (hot_idx(led_o) + 1) % NSW;
    sw_i[i] = ~sw_i[i];
    el--;
    if (el == 0) begin
`ifdef HISCORE_EN
      if (es > ehi) ehi = es;
`endif
      push(es, 0, 5, 0, 1);
    end else push(es, el, 5, 1, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic glitch();
    int i;
    i = hot_idx(led_o);
    sw_i[i] = ~sw_i[i];
    repeat (2) @(negedge clk);
    sw_i[i] = ~sw_i[i];
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_once();
    tick_i = 1'b1; @(negedge clk); tick_i = 1'b0; @(negedge clk);
  endtask

  initial begin
    int i;
    push(0, 3, 5, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Game 1: answers, rejected glitch, three misses to game over at score 7
    start_game();
    correct();
    glitch();
    repeat (6) correct();
    repeat (3) wrong();

    // Game 2: timeout, then timeout tick coinciding with debounce completion
    start_game();
    for (int t = 4; t >= 1; t--) begin push(es, el, t, 1, 0); tick_once(); end
    push(es, el, 0, 1, 0); el--; push(es, el, 0, 1, 0); push(es, el, 5, 1, 0);
    tick_once();
    @(negedge clk);

    for (int t = 4; t >= 1; t--) begin push(es, el, t, 1, 0); tick_once(); end
    i = hot_idx(led_o);
    sw_i[i] = ~sw_i[i];
    push(es, el, 0, 1, 0); es++; push(es, el, 0, 1, 0); push(es, el, 5, 1, 0);
    repeat (4) @(negedge clk);
    tick_i = 1'b1; @(negedge clk); tick_i = 1'b0;
    repeat (2) @(negedge clk);

    // Saturate at 99, one more correct answer must not move the score
    while (es < 99) correct();
    correct();
    repeat (2) wrong();
    repeat (4) @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending events, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
